// File: rtl/lifo_stack_param.sv
// lifo_stack_param
// Parametrised synchronous LIFO stack with occupancy count, combinational
// top-of-stack peek, push+pop replace, a one-cycle pop valid strobe and
// sticky overflow/underflow error flags. Single clock domain.
//
// Ports:
//   Clk        rising-edge clock
//   RstN       synchronous reset, active-low
//   Push       push Data_In this cycle
//   Pop        pop the top entry this cycle (Push+Pop together = replace)
//   Data_In    word to push
//   Clr_Err    clears Overflow/Underflow (an error event in the same cycle wins)
//   Data_Out   last popped word, registered and held
//   Out_Valid  one-cycle pulse after a successful pop/replace
//   Top        combinational peek of the top entry, 0 when Empty
//   Count      number of valid entries, 0..DEPTH
//   Full       Count == DEPTH (registered)
//   Empty      Count == 0 (registered)
//   Overflow   sticky: push attempted while Full without a pop
//   Underflow  sticky: pop attempted while Empty

module lifo_stack_param #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              Clk,
  input  logic              RstN,
  input  logic              Push,
  input  logic              Pop,
  input  logic [DATA_W-1:0] Data_In,
  input  logic              Clr_Err,
  output logic [DATA_W-1:0] Data_Out,
  output logic              Out_Valid,
  output logic [DATA_W-1:0] Top,
  output logic [CNT_W-1:0]  Count,
  output logic              Full,
  output logic              Empty,
  output logic              Overflow,
  output logic              Underflow
);

  // Memory index width; Count needs one more value (DEPTH) than an address does.
  localparam int ADDR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [CNT_W-1:0]  count_m1;
  logic [ADDR_W-1:0] push_idx;
  logic [ADDR_W-1:0] top_idx;

  logic [CNT_W-1:0]  cnt_next;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              pop_ok;
  logic              ovf_evt;
  logic              unf_evt;

  // push_idx is only used when Count < DEPTH, top_idx only when Count > 0,
  // so truncating to ADDR_W bits never aliases a live entry.
  assign count_m1 = Count - CNT_W'(1);
  assign push_idx = Count[ADDR_W-1:0];
  assign top_idx  = count_m1[ADDR_W-1:0];

  // Empty gates the peek so stale memory contents never leak out after reset.
  assign Top = Empty ? '0 : mem[top_idx];

  always_comb begin
    cnt_next = Count;
    wr_en    = 1'b0;
    wr_addr  = push_idx;
    pop_ok   = 1'b0;
    ovf_evt  = 1'b0;
    unf_evt  = 1'b0;
    unique case ({Push, Pop})
      2'b10: begin
        if (!Full) begin
          wr_en    = 1'b1;
          cnt_next = Count + CNT_W'(1);
        end else begin
          ovf_evt = 1'b1;
        end
      end
      2'b01: begin
        if (!Empty) begin
          pop_ok   = 1'b1;
          cnt_next = count_m1;
        end else begin
          unf_evt = 1'b1;
        end
      end
      2'b11: begin
        if (!Empty) begin
          // Replace: read old top and overwrite it in the same edge; depth unchanged.
          pop_ok  = 1'b1;
          wr_en   = 1'b1;
          wr_addr = top_idx;
        end else begin
          // Nothing to pop, so the push still happens but the pop is an error.
          wr_en    = 1'b1;
          cnt_next = CNT_W'(1);
          unf_evt  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!RstN) begin
      Count     <= '0;
      Empty     <= 1'b1;
      Full      <= 1'b0;
      Data_Out  <= '0;
      Out_Valid <= 1'b0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      Count     <= cnt_next;
      Full      <= (cnt_next == CNT_W'(DEPTH));
      Empty     <= (cnt_next == '0);
      Out_Valid <= pop_ok;
      if (pop_ok) begin
        Data_Out <= mem[top_idx];
      end
      Overflow  <= ovf_evt | (Overflow & ~Clr_Err);
      Underflow <= unf_evt | (Underflow & ~Clr_Err);
    end
  end

  // Storage is never cleared; reset only blocks writes so a push during reset is dropped.
  always_ff @(posedge Clk) begin
    if (RstN && wr_en) begin
      mem[wr_addr] <= Data_In;
    end
  end

endmodule

// File: tb/tb_lifo_stack_param.sv
// tb_lifo_stack_param
// Directed bench for lifo_stack_param (DATA_W=4, DEPTH=8). Inputs change on
// the falling edge; outputs are sampled 1 time unit after the rising edge.

module tb_lifo_stack_param;

  logic       Clk = 1'b0;
  logic       RstN;
  logic       Push;
  logic       Pop;
  logic [3:0] Data_In;
  logic       Clr_Err;
  logic [3:0] Data_Out;
  logic       Out_Valid;
  logic [3:0] Top;
  logic [3:0] Count;
  logic       Full;
  logic       Empty;
  logic       Overflow;
  logic       Underflow;

  int checks = 0;
  int errors = 0;

  lifo_stack_param #(.DATA_W(4), .DEPTH(8)) dut (
    .Clk       (Clk),
    .RstN      (RstN),
    .Push      (Push),
    .Pop       (Pop),
    .Data_In   (Data_In),
    .Clr_Err   (Clr_Err),
    .Data_Out  (Data_Out),
    .Out_Valid (Out_Valid),
    .Top       (Top),
    .Count     (Count),
    .Full      (Full),
    .Empty     (Empty),
    .Overflow  (Overflow),
    .Underflow (Underflow)
  );

  always #5 Clk = ~Clk;

  // Drive one cycle of inputs and return just after the rising edge that takes them.
  task automatic applyStimulus(input logic rstn, input logic push, input logic pop,
                               input logic [3:0] din, input logic clr);
    @(negedge Clk);
    RstN    = rstn;
    Push    = push;
    Pop     = pop;
    Data_In = din;
    Clr_Err = clr;
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    RstN = 1'b0; Push = 1'b0; Pop = 1'b0; Data_In = 4'h0; Clr_Err = 1'b0;

    // Reset state
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    checkOutput("rst_count",  32'(Count),     32'd0);
    checkOutput("rst_empty",  32'(Empty),     32'd1);
    checkOutput("rst_full",   32'(Full),      32'd0);
    checkOutput("rst_top",    32'(Top),       32'd0);
    checkOutput("rst_ovf",    32'(Overflow),  32'd0);
    checkOutput("rst_unf",    32'(Underflow), 32'd0);
    checkOutput("rst_valid",  32'(Out_Valid), 32'd0);
    checkOutput("rst_dout",   32'(Data_Out),  32'd0);

    // Fill with 1..8
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 4'(i), 1'b0);
      checkOutput("fill_top",   32'(Top),   32'(i));
      checkOutput("fill_count", 32'(Count), 32'(i));
      checkOutput("fill_empty", 32'(Empty), 32'd0);
    end
    checkOutput("fill_full", 32'(Full), 32'd1);

    // Push while full
    applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, 1'b0);
    checkOutput("ovf_flag",  32'(Overflow), 32'd1);
    checkOutput("ovf_count", 32'(Count),    32'd8);
    checkOutput("ovf_top",   32'(Top),      32'd8);
    checkOutput("ovf_full",  32'(Full),     32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    checkOutput("ovf_sticky", 32'(Overflow), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 1'b1);
    checkOutput("ovf_clr", 32'(Overflow), 32'd0);

    // Drain: 8,7..1
    for (int i = 8; i >= 1; i--) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 4'h0, 1'b0);
      checkOutput("pop_dout",  32'(Data_Out),  32'(i));
      checkOutput("pop_valid", 32'(Out_Valid), 32'd1);
      checkOutput("pop_count", 32'(Count),     32'(i - 1));
      checkOutput("pop_full",  32'(Full),      32'd0);
    end
    checkOutput("drain_empty", 32'(Empty), 32'd1);
    checkOutput("drain_top",   32'(Top),   32'd0);

    // Idle drops the strobe and holds Data_Out
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    checkOutput("idle_valid", 32'(Out_Valid), 32'd0);
    checkOutput("idle_dout",  32'(Data_Out),  32'd1);

    // Pop while empty
    applyStimulus(1'b1, 1'b0, 1'b1, 4'h0, 1'b0);
    checkOutput("unf_flag",  32'(Underflow), 32'd1);
    checkOutput("unf_valid", 32'(Out_Valid), 32'd0);
    checkOutput("unf_dout",  32'(Data_Out),  32'd1);
    checkOutput("unf_count", 32'(Count),     32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 1'b1);
    checkOutput("unf_clr", 32'(Underflow), 32'd0);

    // Push+Pop on empty acts as push with underflow
    applyStimulus(1'b1, 1'b1, 1'b1, 4'h5, 1'b0);
    checkOutput("pp0_count", 32'(Count),     32'd1);
    checkOutput("pp0_top",   32'(Top),       32'd5);
    checkOutput("pp0_unf",   32'(Underflow), 32'd1);
    checkOutput("pp0_valid", 32'(Out_Valid), 32'd0);
    checkOutput("pp0_empty", 32'(Empty),     32'd0);

    // Replace on [3,9]
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    checkOutput("rst2_unf", 32'(Underflow), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'h3, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'h9, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'hA, 1'b0);
    checkOutput("rep_dout",  32'(Data_Out),  32'h9);
    checkOutput("rep_valid", 32'(Out_Valid), 32'd1);
    checkOutput("rep_count", 32'(Count),     32'd2);
    checkOutput("rep_top",   32'(Top),       32'hA);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'h0, 1'b0);
    checkOutput("rep_pop1", 32'(Data_Out), 32'hA);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'h0, 1'b0);
    checkOutput("rep_pop2",   32'(Data_Out), 32'h3);
    checkOutput("rep_pop2_e", 32'(Empty),    32'd1);

    // Replace while full: no overflow
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 4'(i + 8), 1'b0);
    end
    checkOutput("full2", 32'(Full), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'hD, 1'b0);
    checkOutput("repf_ovf",   32'(Overflow),  32'd0);
    checkOutput("repf_count", 32'(Count),     32'd8);
    checkOutput("repf_full",  32'(Full),      32'd1);
    checkOutput("repf_top",   32'(Top),       32'hD);
    checkOutput("repf_dout",  32'(Data_Out),  32'hF);
    checkOutput("repf_valid", 32'(Out_Valid), 32'd1);

    // Reset while pushing discards entries
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'h1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'h2, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'h3, 1'b0);
    checkOutput("pre_rst_count", 32'(Count), 32'd3);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h7, 1'b0);
    checkOutput("midrst_count", 32'(Count), 32'd0);
    checkOutput("midrst_empty", 32'(Empty), 32'd1);
    checkOutput("midrst_top",   32'(Top),   32'd0);

    // Overflow event and Clr_Err in the same cycle: set wins
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 4'(i), 1'b0);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 4'hE, 1'b1);
    checkOutput("setwin_ovf",   32'(Overflow), 32'd1);
    checkOutput("setwin_top",   32'(Top),      32'd7);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 1'b1);
    checkOutput("setwin_clr",   32'(Overflow), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
